// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the execute-stage ALU control codes the unit sits beside.
package mul_div_unit_pkg;

    localparam int MDU_W = 32;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

    // Two's-complement magnitude; 32'h80000000 maps to 2^31 as an unsigned value.
    function automatic logic [MDU_W-1:0] mag(input logic [MDU_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// Radix-2 restoring divider core on unsigned magnitudes: one quotient bit per
// step, dividend shifted out of the quotient register as quotient bits shift in.
module div_iter #(
    parameter int ITERS = 32,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         last
);

    localparam int CW = $clog2(ITERS);

    logic [CW-1:0] cnt_q;
    logic [W-1:0]  q_q;
    logic [W-1:0]  r_q;
    logic [W-1:0]  d_q;
    logic [W:0]    shifted;
    logic [W:0]    trial;

    // Remainder stays below the divisor, so one extra bit holds the shifted value;
    // the top bit of the trial difference is the borrow.
    always_comb begin
        shifted = {r_q, q_q[W-1]};
        trial   = shifted - {1'b0, d_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            q_q   <= '0;
            r_q   <= '0;
            d_q   <= '0;
        end else if (load) begin
            cnt_q <= '0;
            q_q   <= dividend;
            r_q   <= '0;
            d_q   <= divisor;
        end else if (step) begin
            cnt_q <= cnt_q + 1'b1;
            if (!trial[W]) begin
                r_q <= trial[W-1:0];
                q_q <= {q_q[W-2:0], 1'b1};
            end else begin
                r_q <= shifted[W-1:0];
                q_q <= {q_q[W-2:0], 1'b0};
            end
        end
    end

    assign quotient  = q_q;
    assign remainder = r_q;
    assign last      = (cnt_q == CW'(ITERS - 1));

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Holds busy while an operation is in flight; MTHI/MTLO writes land only when idle.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output mdu_state_e  dbg_state
);

    // Handshake: start is accepted only when busy=0 and cancel=0; busy rises at the
    // accepting edge and falls at the result edge, where done pulses for one cycle.

    mdu_state_e  state_q, state_d;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        div_zero_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        accept;
    logic        div_step;
    logic        div_last;
    logic [31:0] quot, rem;
    logic [31:0] a_mag, b_mag;
    logic [63:0] a_ext, b_ext, product;
    logic        neg_quot, neg_rem;
    logic [31:0] fix_lo, fix_hi;

    assign accept   = (state_q == ST_IDLE) && start && !cancel;
    assign div_step = (state_q == ST_DIV) && !div_zero_q && !cancel;

    assign a_mag = mag(a, (op == MDU_DIV) && a[31]);
    assign b_mag = mag(b, (op == MDU_DIV) && b[31]);

    div_iter #(.ITERS(DIV_ITERS), .W(32)) u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && op[1]),
        .step      (div_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quot),
        .remainder (rem),
        .last      (div_last)
    );

    // Extending both operands to 64 bits makes the truncated product exact for both signednesses.
    always_comb begin
        a_ext    = op_q[0] ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
        b_ext    = op_q[0] ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
        product  = a_ext * b_ext;
        neg_quot = (op_q == MDU_DIV) && (a_q[31] ^ b_q[31]);
        neg_rem  = (op_q == MDU_DIV) && a_q[31];
        fix_lo   = div_zero_q ? 32'hFFFF_FFFF : mag(quot, neg_quot);
        fix_hi   = div_zero_q ? a_q : mag(rem, neg_rem);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = op[1] ? ST_DIV : ST_MUL;
            ST_MUL:  state_d = ST_IDLE;
            ST_DIV:  if (div_zero_q || div_last) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (cancel && state_q != ST_IDLE) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (accept) begin
                op_q       <= op;
                a_q        <= a;
                b_q        <= b;
                div_zero_q <= (b == 32'd0);
            end
            if (state_q == ST_IDLE) begin
                if (hi_we) hi_q <= wdata;
                if (lo_we) lo_q <= wdata;
            end
            if (state_q == ST_MUL && !cancel) begin
                hi_q   <= product[63:32];
                lo_q   <= product[31:0];
                done_q <= 1'b1;
            end
            if (state_q == ST_FIX && !cancel) begin
                hi_q   <= fix_hi;
                lo_q   <= fix_lo;
                done_q <= 1'b1;
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random operations
// compared against a plain-arithmetic reference model via an expected queue.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        cancel;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;
    mdu_state_e  dbg_state;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];

    mul_div_unit #(.DIV_ITERS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .cancel    (cancel),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {hi, lo} from the architectural definition using wide integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] ux, uy, res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        res = '0;
        case (o)
            MDU_MULT:  res = sx * sy;
            MDU_MULTU: res = ux * uy;
            default: begin
                if (y == 32'd0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else if (o == MDU_DIV) begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {(ux % uy) & 64'hFFFF_FFFF, 32'b0} | ((ux / uy) & 64'hFFFF_FFFF);
                end
            end
        endcase
        return res;
    endfunction

    function automatic int exp_latency(input logic [1:0] o, input logic [31:0] y);
        if (!o[1]) return 1;
        if (y == 32'd0) return 2;
        return 33;
    endfunction

    task automatic idle_inputs();
        start  = 1'b0;
        cancel = 1'b0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        wdata  = '0;
    endtask

    // driver: issue one operation, wait for completion (bounded), score the result
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int          n;
        logic [63:0] e;
        exp_q.push_back(ref_model(o, x, y));
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        n = 0;
        while (busy && n < 200) begin
            check({tag, "_nodone_busy"}, {63'b0, done}, 64'd0);
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, 64'(n), 64'(exp_latency(o, y)));
        check({tag, "_done"}, {63'b0, done}, 64'd1);
        e = exp_q.pop_front();
        check({tag, "_hilo"}, {hi, lo}, e);
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        hi_we = 1'b1; wdata = h;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = l;
        @(negedge clk);
        lo_we = 1'b0;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);

        // directed arithmetic
        run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        check("mult_neg_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_exact", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7);
        check("divu_exact", {hi, lo}, {32'd2, 32'd14});
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_exact", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op("divu_zero", MDU_DIVU, 32'd5, 32'd0);
        check("divu_zero_exact", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        run_op("div_zero", MDU_DIV, 32'hFFFF_FF00, 32'd0);

        // MTHI / MTLO in idle
        write_hilo(32'h0000_1234, 32'h0000_5678);
        check("mthi", {32'b0, hi}, 64'h1234);
        check("mtlo", {32'b0, lo}, 64'h5678);

        // cancel mid-DIV with an ignored second start
        @(negedge clk);
        start = 1'b1; op = MDU_DIVU; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (c == 5) begin
                start = 1'b1; op = MDU_MULT; a = 32'd9; b = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            check("cancel_prebusy", {62'b0, busy, done}, 64'd2);
        end
        start = 1'b0; cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {62'b0, busy, done}, 64'd0);
        check("cancel_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
        repeat (3) begin
            @(negedge clk);
            check("cancel_nodone", {62'b0, busy, done}, 64'd0);
        end

        // start together with cancel in idle is ignored
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = MDU_MULTU; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("start_cancel_idle", {63'b0, busy}, 64'd0);

        // hi_we while busy ignored, then reset mid-DIV
        @(negedge clk);
        start = 1'b1; op = MDU_DIV; a = 32'd77; b = 32'd5;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("we_busy_ignored", {hi, lo}, 64'h0000_1234_0000_5678);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_div", {31'b0, busy, hi}, 64'd0);
        check("rst_mid_div_lo", {31'b0, done, lo}, 64'd0);

        // random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op("rand", ro, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
